// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - encodings, field positions and issue states shared by the issue block
package isa_pkg;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;

  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam int OPCODE_LSB = 13;
  localparam int ALU_OP_LSB = 11;
  localparam int RN_LSB     = 8;
  localparam int RD_LSB     = 5;
  localparam int SHIFT_LSB  = 3;
  localparam int RM_LSB     = 0;

  typedef logic [1:0] issue_state_t;
  localparam issue_state_t IDLE    = 2'd0;
  localparam issue_state_t ISSUE   = 2'd1;
  localparam issue_state_t WAIT_LO = 2'd2;
  localparam issue_state_t WAIT_HI = 2'd3;

  // MOV only exists in immediate and register forms; every ALU sub-op is valid
  function automatic logic is_legal(input logic [2:0] op, input logic [1:0] alu);
    case (op)
      OP_MOV:  is_legal = (alu == MOV_IMM) || (alu == MOV_REG);
      OP_ALU:  is_legal = (alu == ALU_ADD) || (alu == ALU_CMP) ||
                          (alu == ALU_AND) || (alu == ALU_MVN);
      default: is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - power-of-two instruction queue with occupancy counter
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // full is judged before any same-cycle pop, so a full queue never accepts
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // storage, wrapping pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_issue.sv
// rtl/instr_issue.sv - buffers instructions, issues them one at a time and tracks completion
module instr_issue
  import isa_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        waiting,
  output logic        start,
  output logic [2:0]  opcode,
  output logic [1:0]  ALU_op,
  output logic [1:0]  shift_op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [15:0] imm8_sx,
  output logic [15:0] imm5_sx,
  output logic        busy,
  output logic [15:0] retired,
  output logic        err_illegal,
  output logic        err_timeout
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  issue_state_t   state;
  logic [15:0]    ir;
  logic [15:0]    head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           head_legal;
  logic [WDW-1:0] wd;

  instr_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (state == IDLE),
    .wdata (in_instr),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready   = !fifo_full;
  assign head_legal = is_legal(head[OPCODE_LSB +: 3], head[ALU_OP_LSB +: 2]);

  assign opcode   = ir[OPCODE_LSB +: 3];
  assign ALU_op   = ir[ALU_OP_LSB +: 2];
  assign shift_op = ir[SHIFT_LSB +: 2];
  assign rn       = ir[RN_LSB +: 3];
  assign rd       = ir[RD_LSB +: 3];
  assign rm       = ir[RM_LSB +: 3];
  assign imm8_sx  = {{8{ir[7]}}, ir[7:0]};
  assign imm5_sx  = {{11{ir[4]}}, ir[4:0]};

  // issue sequencing: load, offer start while the controller is ready, then watch waiting fall and rise
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ir          <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      retired     <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      wd          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (head_legal) begin
              ir    <= head;
              busy  <= 1'b1;
              start <= waiting;
              state <= ISSUE;
            end else begin
              err_illegal <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (start && waiting) begin
            start <= 1'b0;
            wd    <= '0;
            state <= WAIT_LO;
          end else begin
            start <= waiting;
          end
        end
        WAIT_LO, WAIT_HI: begin
          wd <= wd + 1'b1;
          if (state == WAIT_HI && waiting) begin
            retired <= retired + 16'd1;
            ir      <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (wd == WD_LAST) begin
            err_timeout <= 1'b1;
            ir          <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (state == WAIT_LO && !waiting) begin
            state <= WAIT_HI;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue.sv
// tb/tb_instr_issue.sv - directed stimulus with a transaction-level model and per-cycle compare
module tb_instr_issue;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic [15:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        waiting;
  logic        start;
  logic [2:0]  opcode;
  logic [1:0]  ALU_op;
  logic [1:0]  shift_op;
  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [2:0]  rm;
  logic [15:0] imm8_sx;
  logic [15:0] imm5_sx;
  logic        busy;
  logic [15:0] retired;
  logic        err_illegal;
  logic        err_timeout;

  instr_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
    .waiting(waiting), .start(start), .opcode(opcode), .ALU_op(ALU_op), .shift_op(shift_op),
    .rn(rn), .rd(rd), .rm(rm), .imm8_sx(imm8_sx), .imm5_sx(imm5_sx), .busy(busy),
    .retired(retired), .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  int passed = 0;
  int total  = 0;
  bit cmp_en = 0;

  // controller emulation knobs: 0 = behaves like the FSM, 1 = forced low, 2 = forced high
  int ctl_mode = 0;
  int ctl_lat  = 3;
  int ctl_left = 0;

  // model state: what the spec says is queued, held, launched and counted
  int q[$];
  bit m_has, m_launched, m_saw_low, m_start, m_eill, m_eto, m_acc;
  int m_cur, m_elapsed, m_retired, m_head;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit legal(input int w);
    int op, a;
    op = (w >> 13) & 7;
    a  = (w >> 11) & 3;
    return (op == 6 && (a == 2 || a == 0)) || op == 5;
  endfunction

  function automatic int sx(input int v, input int bits);
    int m;
    m = v & ((1 << bits) - 1);
    if (m >= (1 << (bits - 1))) m = m + 65536 - (1 << bits);
    return m;
  endfunction

  // behavioural model, advanced on every rising edge from the inputs the DUT also sees
  initial forever begin
    @(posedge clk);
    m_acc = in_valid && (q.size() < DEPTH);
    if (rst) begin
      q.delete();
      m_has = 0; m_launched = 0; m_saw_low = 0; m_start = 0;
      m_eill = 0; m_eto = 0; m_cur = 0; m_elapsed = 0; m_retired = 0;
    end else begin
      if (!m_has) begin
        if (q.size() > 0) begin
          m_head = q.pop_front();
          if (legal(m_head)) begin
            m_has = 1; m_cur = m_head; m_launched = 0; m_start = waiting;
          end else m_eill = 1;
        end
      end else if (!m_launched) begin
        if (m_start && waiting) begin
          m_launched = 1; m_saw_low = 0; m_elapsed = 0; m_start = 0;
        end else m_start = waiting;
      end else begin
        m_elapsed++;
        if (m_saw_low && waiting) begin
          m_retired = (m_retired + 1) & 16'hFFFF;
          m_has = 0;
        end else if (m_elapsed >= TIMEOUT) begin
          m_eto = 1;
          m_has = 0;
        end else if (!waiting) m_saw_low = 1;
      end
      if (m_acc) q.push_back(int'(in_instr));
    end
  end

  // per-cycle compare of every output against the model
  initial forever begin
    int ir;
    @(negedge clk);
    if (cmp_en) begin
      ir = m_has ? m_cur : 0;
      chk("in_ready", int'(in_ready), int'(q.size() < DEPTH));
      chk("start", int'(start), int'(m_start));
      chk("busy", int'(busy), int'(m_has));
      chk("opcode", int'(opcode), (ir >> 13) & 7);
      chk("ALU_op", int'(ALU_op), (ir >> 11) & 3);
      chk("shift_op", int'(shift_op), (ir >> 3) & 3);
      chk("rn", int'(rn), (ir >> 8) & 7);
      chk("rd", int'(rd), (ir >> 5) & 7);
      chk("rm", int'(rm), ir & 7);
      chk("imm8_sx", int'(imm8_sx), sx(ir, 8));
      chk("imm5_sx", int'(imm5_sx), sx(ir, 5));
      chk("retired", int'(retired), m_retired);
      chk("err_illegal", int'(err_illegal), int'(m_eill));
      chk("err_timeout", int'(err_timeout), int'(m_eto));
    end
  end

  // controller emulation: accepts start while waiting, then drops waiting for ctl_lat cycles
  initial begin
    waiting = 1;
    forever begin
      @(negedge clk);
      if (ctl_mode == 1) waiting = 0;
      else if (ctl_mode == 2) begin
        waiting = 1;
        ctl_left = 0;
      end else if (ctl_left > 0) begin
        waiting = 0;
        ctl_left--;
      end else begin
        waiting = 1;
        if (start) ctl_left = ctl_lat;
      end
    end
  end

  // call at a falling edge; returns at the falling edge after the accepting rising edge
  task automatic push(input logic [15:0] w, output bit ok);
    ok = 0;
    in_valid = 1;
    in_instr = w;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit && (m_has || q.size() != 0); i++) @(negedge clk);
    if (m_has || q.size() != 0) chk("wait_idle_bound", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    int pulses, n;
    rst = 1; in_valid = 0; in_instr = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    cmp_en = 1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_retired", int'(retired), 0);
    chk("reset_start", int'(start), 0);

    push(16'hD205, ok);
    chk("a_push", int'(ok), 1);
    chk("a_start_before", int'(start), 0);
    @(negedge clk);
    chk("a_start", int'(start), 1);
    chk("a_opcode", int'(opcode), 6);
    chk("a_alu", int'(ALU_op), 2);
    chk("a_rn", int'(rn), 2);
    chk("a_imm8", int'(imm8_sx), 16'h0005);
    @(negedge clk);
    chk("a_start_once", int'(start), 0);
    wait_idle(100);
    chk("a_retired", int'(retired), 1);

    push(16'hD0FF, ok);
    @(negedge clk);
    chk("b_imm8", int'(imm8_sx), 16'hFFFF);
    chk("b_imm5", int'(imm5_sx), 16'hFFFF);
    chk("b_rd", int'(rd), 7);
    wait_idle(100);
    chk("b_retired", int'(retired), 2);

    ctl_mode = 1;
    push(16'hA0A1, ok);
    @(negedge clk);
    chk("c_busy", int'(busy), 1);
    chk("c_opcode", int'(opcode), 5);
    chk("c_rd", int'(rd), 5);
    chk("c_rm", int'(rm), 1);
    chk("c_rn", int'(rn), 0);
    for (int i = 0; i < 3; i++) begin
      chk("c_start_held", int'(start), 0);
      @(negedge clk);
    end
    ctl_mode = 0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pulses += int'(start);
    end
    chk("c_pulses", pulses, 1);
    wait_idle(100);
    chk("c_retired", int'(retired), 3);

    push(16'hE000, ok);
    push(16'hA800, ok);
    wait_idle(100);
    chk("d_err_illegal", int'(err_illegal), 1);
    chk("d_retired", int'(retired), 4);

    ctl_lat = 20;
    push(16'hA800, ok);
    wait_idle(100);
    chk("e_err_timeout", int'(err_timeout), 1);
    chk("e_busy", int'(busy), 0);
    chk("e_retired", int'(retired), 4);
    for (int i = 0; i < 40 && !waiting; i++) @(negedge clk);
    ctl_lat = 3;

    ctl_mode = 2;
    push(16'hA000, ok);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      push(16'hA100 + 16'(i), ok);
      n += int'(ok);
    end
    chk("f_accepted4", n, 4);
    chk("f_full", int'(in_ready), 0);
    push(16'hA1FF, ok);
    chk("f_fifth", int'(ok), 1);
    ctl_mode = 0;
    wait_idle(400);

    ctl_lat = 10;
    push(16'hA800, ok);
    for (int i = 0; i < 50 && !(busy && !waiting); i++) @(negedge clk);
    @(negedge clk); @(negedge clk);
    chk("g_busy_before", int'(busy), 1);
    rst = 1;
    ctl_mode = 2;
    @(negedge clk);
    rst = 0;
    ctl_mode = 0;
    ctl_lat = 3;
    chk("g_in_ready", int'(in_ready), 1);
    chk("g_start", int'(start), 0);
    chk("g_retired", int'(retired), 0);
    chk("g_busy", int'(busy), 0);
    chk("g_err_timeout", int'(err_timeout), 0);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
